// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0, MSB-first SPI byte engine that generates SCLK, drives MOSI and samples MISO.
// Each byte spans 16 SCLK half-periods of CLK_DIV clocks each, and done pulses for one cycle at the end.
module spi_byte_shifter #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    state_t           state, state_n;
    logic [CNT_W-1:0] div_cnt, div_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       tx_sr, tx_sr_n, rx_sr, rx_sr_n, rx_byte_n;
    logic             sclk_n, mosi_n, busy_n, done_n, half_end;
    assign half_end = div_cnt == DIV_LAST;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_byte <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            bit_cnt <= bit_cnt_n;
            tx_sr   <= tx_sr_n;
            rx_sr   <= rx_sr_n;
            rx_byte <= rx_byte_n;
            sclk    <= sclk_n;
            mosi    <= mosi_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        bit_cnt_n = bit_cnt;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        rx_byte_n = rx_byte;
        sclk_n    = sclk;
        mosi_n    = mosi;
        busy_n    = busy;
        done_n    = 1'b0;
        case (state)
            IDLE: if (start) begin
                tx_sr_n   = tx_byte;
                mosi_n    = tx_byte[7];
                busy_n    = 1'b1;
                div_cnt_n = '0;
                bit_cnt_n = '0;
                state_n   = LOW;
            end
            LOW: if (half_end) begin
                sclk_n    = 1'b1;
                rx_sr_n   = {rx_sr[6:0], miso};
                div_cnt_n = '0;
                state_n   = HIGH;
            end else div_cnt_n = div_cnt + 1'b1;
            HIGH: if (half_end) begin
                sclk_n    = 1'b0;
                div_cnt_n = '0;
                // MOSI only moves on the falling edge, so it is stable across the next rise
                if (bit_cnt != 3'd7) begin
                    tx_sr_n   = {tx_sr[6:0], 1'b0};
                    mosi_n    = tx_sr[6];
                    bit_cnt_n = bit_cnt + 3'd1;
                    state_n   = LOW;
                end else begin
                    done_n    = 1'b1;
                    busy_n    = 1'b0;
                    rx_byte_n = rx_sr;
                    mosi_n    = 1'b0;
                    state_n   = IDLE;
                end
            end else div_cnt_n = div_cnt + 1'b1;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_byte_shifter.sv
// tb_spi_byte_shifter: directed vectors against a CLK_DIV=2 instance (pattern MISO) and a CLK_DIV=1 instance (loopback).
module tb_spi_byte_shifter;
    typedef struct {
        logic       lb;
        logic       tie;
        logic [7:0] tx;
        logic [7:0] pat;
        logic [7:0] exp_rx;
        int         poke;
    } vec_t;

    logic       clk = 1'b0, reset = 1'b0, start = 1'b0, sel = 1'b0, tie = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       busy_a, done_a, sclk_a, mosi_a, miso_a, start_a;
    logic       busy_b, done_b, sclk_b, mosi_b, start_b;
    logic [7:0] rx_a, rx_b;
    logic       s_busy, s_done, s_sclk, s_mosi;
    logic [7:0] s_rx;
    logic [7:0] pats [4];
    int         falls = 0, base = 0, nf;
    int         nvec = 0, nbad = 0;
    vec_t       vecs [6];

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign s_busy  = sel ? busy_b : busy_a;
    assign s_done  = sel ? done_b : done_a;
    assign s_sclk  = sel ? sclk_b : sclk_a;
    assign s_mosi  = sel ? mosi_b : mosi_a;
    assign s_rx    = sel ? rx_b : rx_a;

    // slave model: presents the next pattern bit after each SCLK fall
    always @(negedge sclk_a) falls = falls + 1;
    assign nf = falls - base;
    always_comb miso_a = tie | (nf >= 0 && nf < 32 && pats[nf[4:3]][3'd7 - nf[2:0]]);

    spi_byte_shifter #(.CLK_DIV(2), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tx_byte(tx_byte), .busy(busy_a), .done(done_a),
        .rx_byte(rx_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a));

    spi_byte_shifter #(.CLK_DIV(1), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_byte(tx_byte), .busy(busy_b), .done(done_b),
        .rx_byte(rx_b), .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b));

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_check(input int n);
        logic quiet = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (s_busy || s_done || s_sclk || s_mosi) quiet = 1'b0;
        end
        chk("idle_quiet", int'(quiet), 1);
    endtask

    task automatic run(input vec_t v);
        int d = v.lb ? 1 : 2;
        int k = 0, busyc = 0, rises = 0, dk = -1;
        logic [7:0] mb = 8'h00;
        logic prev;
        @(negedge clk);
        sel = v.lb; tie = v.tie; pats[0] = v.pat; base = falls;
        tx_byte = v.tx; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        tx_byte = ~v.tx;
        prev = s_sclk;
        while (k < 40 * d) begin
            @(negedge clk);
            if (s_busy) busyc++;
            if (s_sclk && !prev) begin
                rises++;
                mb = {mb[6:0], s_mosi};
            end
            prev = s_sclk;
            if (v.poke == k) begin
                start = 1'b1;
                tx_byte = 8'hFF;
            end else start = 1'b0;
            if (s_done) begin
                dk = k;
                break;
            end
            k++;
        end
        start = 1'b0;
        chk("done_cycle", dk, 16 * d);
        chk("busy_cycles", busyc, 16 * d);
        chk("rise_count", rises, 8);
        chk("mosi_bits", int'(mb), int'(v.tx));
        chk("rx_byte", int'(s_rx), int'(v.exp_rx));
        idle_check(20);
        chk("rx_hold", int'(s_rx), int'(v.exp_rx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d [3];
        logic [7:0] r [3];
        int n, lows;
        vecs[0] = '{lb: 1'b0, tie: 1'b0, tx: 8'h9F, pat: 8'hEF, exp_rx: 8'hEF, poke: -1};
        vecs[1] = '{lb: 1'b0, tie: 1'b1, tx: 8'hAA, pat: 8'h00, exp_rx: 8'hFF, poke: -1};
        vecs[2] = '{lb: 1'b1, tie: 1'b0, tx: 8'h55, pat: 8'h00, exp_rx: 8'h55, poke: -1};
        vecs[3] = '{lb: 1'b0, tie: 1'b0, tx: 8'h3C, pat: 8'hC3, exp_rx: 8'hC3, poke: 13};
        vecs[4] = '{lb: 1'b0, tie: 1'b0, tx: 8'h00, pat: 8'h20, exp_rx: 8'h20, poke: -1};
        vecs[5] = '{lb: 1'b1, tie: 1'b0, tx: 8'hA3, pat: 8'h00, exp_rx: 8'hA3, poke: -1};
        pats[0] = 8'h00; pats[1] = 8'h00; pats[2] = 8'h00; pats[3] = 8'h00;

        @(posedge clk);
        #1;
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_sclk", int'(sclk_a), 0);
        chk("reset_rx", int'(rx_a), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i]);

        // back-to-back transfers with start held high
        @(negedge clk);
        sel = 1'b0; tie = 1'b0;
        pats[0] = 8'h20; pats[1] = 8'hBA; pats[2] = 8'h18; pats[3] = 8'h00;
        base = falls; tx_byte = 8'h00; start = 1'b1;
        n = 0; lows = 0;
        for (int c = 0; c < 200 && n < 3; c++) begin
            @(negedge clk);
            if (done_a) begin
                d[n] = c;
                r[n] = rx_a;
                n++;
                if (n == 3) start = 1'b0;
            end
            if (n >= 1 && n < 3 && !busy_a) lows++;
        end
        start = 1'b0;
        chk("b2b_done_count", n, 3);
        chk("b2b_gap1", d[1] - d[0], 33);
        chk("b2b_gap2", d[2] - d[1], 33);
        chk("b2b_rx0", int'(r[0]), 'h20);
        chk("b2b_rx1", int'(r[1]), 'hBA);
        chk("b2b_rx2", int'(r[2]), 'h18);
        chk("b2b_busy_low", lows, 2);
        idle_check(40);

        // asynchronous reset in the middle of bit 4
        @(negedge clk);
        sel = 1'b0; pats[0] = 8'h00; base = falls; tx_byte = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_busy", int'(busy_a), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_sclk", int'(sclk_a), 0);
        chk("async_mosi", int'(mosi_a), 0);
        chk("async_busy", int'(busy_a), 0);
        chk("async_done", int'(done_a), 0);
        chk("async_rx", int'(rx_a), 0);
        repeat (3) @(negedge clk);
        chk("held_reset_busy", int'(busy_a), 0);
        reset = 1'b1;
        run('{lb: 1'b0, tie: 1'b0, tx: 8'hA5, pat: 8'h5A, exp_rx: 8'h5A, poke: -1});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/spi_byte_shifter.md
Name: spi_byte_shifter

Overview:
Bit-level SPI engine that sits directly below the RDID control FSM. The FSM owns chip-select and sequencing. It hands this block one byte at a time: the 0x9F instruction byte, then dummy bytes while the 3 ID bytes return. This block generates SCLK (mode 0, MSB first), drives MOSI, samples MISO, and returns the received byte with a one-cycle done pulse.

Parameters:
CLK_DIV, 4, system clk cycles per SCLK half-period; legal range 1..255
CNT_W, 8, width of the half-period counter; must hold CLK_DIV-1

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  request a byte transfer; sampled only when busy=0
tx_byte  in  8  byte to transmit; captured on the accepted start edge
busy  out  1  high while a transfer is in progress
done  out  1  one-cycle pulse marking the end of a transfer
rx_byte  out  8  last fully received byte; valid from the done edge, held until the next done
sclk  out  1  SPI serial clock; idle low
mosi  out  1  serial data out, MSB first
miso  in  1  serial data in; externally synchronous to sclk, no synchronizer required

Behaviour:
- Reset (reset=0, async): state=IDLE; sclk=0, mosi=0, busy=0, done=0, rx_byte=8'h00; all counters and shift registers cleared. Applies immediately, including mid-transfer; no partial done is issued.
- States: IDLE, LOW, HIGH. All outputs are registered.
- IDLE: sclk=0, mosi=0, busy=0.
  - On an edge with start=1: load tx shift reg = tx_byte; mosi <= tx_byte[7]; busy <= 1; div_cnt <= 0; bit_cnt <= 0; go to LOW.
- LOW: sclk=0. div_cnt increments each cycle.
  - On the edge where div_cnt==CLK_DIV-1: sclk <= 1; rx shift reg <= {rx_sr[6:0], miso} (sample at rising edge); div_cnt <= 0; go to HIGH.
- HIGH: sclk=1. div_cnt increments each cycle.
  - On the edge where div_cnt==CLK_DIV-1, sclk <= 0 and div_cnt <= 0. Then:
  - If bit_cnt<7: shift the tx reg left; mosi <= next bit; bit_cnt <= bit_cnt+1; go to LOW.
  - If bit_cnt==7: done <= 1; busy <= 0; rx_byte <= assembled rx reg; mosi <= 0; go to IDLE.
- done is high for exactly one cycle, the cycle after the final falling edge is registered. It is deasserted on the next edge unless a new transfer completes.
- Timing: with start accepted at edge T0, the first sclk rise is at T0+CLK_DIV, the 8th rise is at T0+15*CLK_DIV, and the final fall, done and busy-low all occur at T0+16*CLK_DIV. busy is high for exactly 16*CLK_DIV cycles.
- MOSI changes only at start acceptance or on sclk falling edges. It is stable across every rising edge.
- start while busy=1 is ignored; tx_byte changes while busy=1 have no effect.
- Back-to-back: if start=1 in the done cycle (busy=0), it is accepted at the next edge. sclk therefore stays low for CLK_DIV+1 cycles between bytes.
- Exactly 8 rising and 8 falling sclk edges per transfer. sclk is never high in IDLE.
- CLK_DIV=1: sclk = clk/2 during a transfer; all rules above still hold.

Test Plan:
- CLK_DIV=2, start with tx_byte=8'h9F; MISO model drives 8'hEF MSB-first, changing on sclk falls -> mosi at the 8 rises = 1,0,0,1,1,1,1,1; done pulses once at T0+32; rx_byte=8'hEF; busy high for exactly 32 cycles.
- Hold start=1 with tx_byte=8'h00 for three transfers, MISO returns 8'h20, 8'hBA, 8'h18 -> three done pulses, each spaced 33 cycles apart; rx_byte shows 20, BA, 18 in order; busy low exactly one cycle between transfers.
- Pulse start at bit 3 of an active transfer with tx_byte=8'hFF -> ignored; the current byte completes unchanged; exactly one done; no new transfer starts afterwards.
- Assert reset=0 asynchronously between clk edges during bit 4 -> sclk, mosi, busy and done go 0 immediately; rx_byte=8'h00; after release, a fresh start of 8'hA5 completes normally.
- CLK_DIV=1, tx_byte=8'h55, MISO looped back from MOSI -> sclk toggles every cycle; rx_byte=8'h55; done at T0+16.
- MISO tied 1 with tx_byte=8'hAA -> rx_byte=8'hFF; 8 rising edges counted; sclk low and mosi=0 after done.
